agu_mod_seq: RTL and testbench
==============================

AGU_MOD_SEQ -- requirements
Module: agu_mod_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address/data width; all Function text assumes 16.
REQ-002 SHALL have port Clk  in  1  single clock; all state changes on posedge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  in  1  one-cycle request to begin a sequence.
REQ-005 SHALL have port rsel  in  2  index of the M register to use, sampled on start.
REQ-006 SHALL have port base  in  16  first address, sampled on start.
REQ-007 SHALL have port offset  in  16  step N, two's complement, sampled on start.
REQ-008 SHALL have port count  in  16  number of addresses to emit, sampled on start.
REQ-009 SHALL have port m_raddr  out  2  read address driven to an M register-file read port.
REQ-010 SHALL have port m_data  in  16  combinational M register-file read data for m_raddr.
REQ-011 SHALL have port addr_out  out  16  generated address.
REQ-012 SHALL have port addr_valid  out  1  addr_out is valid.
REQ-013 SHALL have port addr_ready  in  1  consumer accepts addr_out.
REQ-014 SHALL have port busy  out  1  a sequence is in progress.
REQ-015 SHALL have port done  out  1  one-cycle pulse at sequence end.

Function
REQ-016 SHALL implement the FSM states IDLE, LOADM, EMIT and FIN.
REQ-017 In IDLE, start=1 SHALL latch rsel, base, offset and count, then go to LOADM; m_raddr SHALL equal the latched rsel.
REQ-018 In LOADM, the block SHALL capture m_data as M; for M in 1..$7FFF, SHALL compute k = smallest k with 2^k > M, lower = base & ~(2^k-1) and upper = lower + M.
REQ-019 From LOADM, count=0 SHALL go to FIN; otherwise SHALL go to EMIT with addr_out=base.
REQ-020 With start at cycle 0, addr_valid SHALL first assert at cycle 2.
REQ-021 In EMIT, addr_valid SHALL be 1, and addr_out SHALL hold stable until addr_valid & addr_ready.
REQ-022 On each handshake, remaining SHALL decrement; at remaining=1 the FSM SHALL go to FIN, otherwise addr_out SHALL load next.
REQ-023 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-024 Next-address rules, by M value:
  - M=$FFFF, and reserved $8000..$FFFE: linear, next = addr + N mod 2^16.
  - M in 1..$7FFF: modulo, t = addr + N.
    - N>=0 and t>upper: next = t-(M+1).
    - N<0 and t<lower: next = t+(M+1).
    - Otherwise next = t.
    - |N| <= M+1 is required of the caller; the result is unspecified otherwise.
  - M=$0000: bit-reverse, next = bitrev16(bitrev16(addr)+bitrev16(N)).
REQ-025 busy SHALL be 1 in LOADM, EMIT and FIN, and 0 in IDLE.
REQ-026 start while busy=1 SHALL be ignored, with no effect on latched values.
REQ-027 addr_valid SHALL be 0 in every state except EMIT.
REQ-028 m_data SHALL be sampled only in LOADM; later changes to the M register SHALL not affect the running sequence.

Reset
REQ-029 While reset=1, asynchronously and regardless of Clk:
  - state SHALL be IDLE.
  - addr_out, m_raddr and the latched registers SHALL be 0.
  - addr_valid, busy and done SHALL be 0.
REQ-030 Reset asserted mid-sequence SHALL drop addr_valid and busy in the same cycle and abandon the sequence, with no done pulse.
REQ-031 After reset deasserts, the block SHALL accept start on the first posedge.

Verification
REQ-032 Linear: M=$FFFF, base=$0100, N=2, count=3, ready=1 -> $0100,$0102,$0104 on consecutive cycles, then done for one cycle.
REQ-033 Modulo wrap: M=$0009, base=$0025, N=3, count=4 -> $0025,$0028,$0021,$0024 (lower $0020, upper $0029).
REQ-034 Modulo negative: M=$0009, base=$0021, N=$FFFD, count=2 -> $0021,$0028.
REQ-035 Bit-reverse: M=$0000, base=$0000, N=$0008, count=4 -> $0000,$0008,$0004,$000C.
REQ-036 Backpressure and restart: addr_ready=0 for 3 cycles during the second address -> addr_out and addr_valid held stable; a start pulse while busy is ignored. Edge cases:
  - count=0 -> no addr_valid, done at cycle 2.
  - Linear $FFFF+1 -> $0000.
REQ-037 Async reset: assert reset between clock edges during EMIT -> addr_valid=0 and busy=0 before the next posedge; no done; a new start after release runs normally.

Source files
------------

// File: rtl/agu_mod_seq.sv
// rtl/agu_mod_seq.sv - address generator: linear, modulo (circular buffer) and bit-reverse sequences
// M is read once per sequence from an external register file; addresses stream out with valid/ready.
module agu_mod_seq #(
  parameter int ADDR_W = 16
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        rsel,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] offset,
  input  logic [ADDR_W-1:0] count,
  output logic [1:0]        m_raddr,
  input  logic [ADDR_W-1:0] m_data,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOADM, EMIT, FIN} state_t;

  state_t            state_q, state_d;
  logic [1:0]        rsel_q, rsel_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] m_q, m_d;
  logic [ADDR_W-1:0] lower_q, lower_d;
  logic [ADDR_W-1:0] upper_q, upper_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] sum;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] next_addr;
  logic signed [ADDR_W+1:0] t_s, lo_s, hi_s;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = v[ADDR_W-1-i];
    return r;
  endfunction

  // Ones at and below the MSB of v, i.e. 2^k-1 for the smallest k with 2^k > v.
  function automatic logic [ADDR_W-1:0] smear(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] r;
    logic              acc;
    acc = 1'b0;
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      acc  = acc | v[i];
      r[i] = acc;
    end
    return r;
  endfunction

  // Wrap decisions use a widened signed sum so carries out of the top bit are not lost.
  always_comb begin
    sum  = addr_q + offset_q;
    span = m_q + ADDR_W'(1);
    t_s  = $signed({2'b00, addr_q}) + $signed({{2{offset_q[ADDR_W-1]}}, offset_q});
    lo_s = $signed({2'b00, lower_q});
    hi_s = $signed({2'b00, upper_q});
    if (m_q == '0) begin
      next_addr = bitrev(bitrev(addr_q) + bitrev(offset_q));
    end else if (m_q[ADDR_W-1]) begin
      next_addr = sum;
    end else if (!offset_q[ADDR_W-1] && (t_s > hi_s)) begin
      next_addr = sum - span;
    end else if (offset_q[ADDR_W-1] && (t_s < lo_s)) begin
      next_addr = sum + span;
    end else begin
      next_addr = sum;
    end
  end

  always_comb begin
    state_d     = state_q;
    rsel_d      = rsel_q;
    base_d      = base_q;
    offset_d    = offset_q;
    count_d     = count_q;
    m_d         = m_q;
    lower_d     = lower_q;
    upper_d     = upper_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    mask        = smear(m_data);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rsel_d   = rsel;
          base_d   = base;
          offset_d = offset;
          count_d  = count;
          state_d  = LOADM;
        end
      end
      LOADM: begin
        m_d         = m_data;
        lower_d     = base_q & ~mask;
        upper_d     = (base_q & ~mask) + m_data;
        remaining_d = count_q;
        if (count_q == '0) begin
          state_d = FIN;
        end else begin
          addr_d  = base_q;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (addr_ready) begin
          if (remaining_q == ADDR_W'(1)) begin
            state_d = FIN;
          end else begin
            remaining_d = remaining_q - ADDR_W'(1);
            addr_d      = next_addr;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rsel_q      <= '0;
      base_q      <= '0;
      offset_q    <= '0;
      count_q     <= '0;
      m_q         <= '0;
      lower_q     <= '0;
      upper_q     <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      rsel_q      <= rsel_d;
      base_q      <= base_d;
      offset_q    <= offset_d;
      count_q     <= count_d;
      m_q         <= m_d;
      lower_q     <= lower_d;
      upper_q     <= upper_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
    end
  end

  assign m_raddr    = rsel_q;
  assign addr_out   = addr_q;
  assign addr_valid = (state_q == EMIT);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);

endmodule

// File: tb/tb_agu_mod_seq.sv
// tb/tb_agu_mod_seq.sv - scoreboard bench for agu_mod_seq
// Stimulus pushes expected addresses; a negedge monitor pops and compares on each handshake.
module tb_agu_mod_seq;

  logic        Clk;
  logic        reset;
  logic        start;
  logic [1:0]  rsel;
  logic [15:0] base;
  logic [15:0] offset;
  logic [15:0] count;
  logic [1:0]  m_raddr;
  logic [15:0] m_data;
  logic [15:0] addr_out;
  logic        addr_valid;
  logic        addr_ready;
  logic        busy;
  logic        done;

  logic [15:0] mreg [4];
  logic [15:0] exp_q [$];
  int          n_checks;
  int          n_fail;
  int          done_cnt;

  assign m_data = mreg[m_raddr];

  agu_mod_seq #(.ADDR_W(16)) dut (
    .Clk        (Clk),
    .reset      (reset),
    .start      (start),
    .rsel       (rsel),
    .base       (base),
    .offset     (offset),
    .count      (count),
    .m_raddr    (m_raddr),
    .m_data     (m_data),
    .addr_out   (addr_out),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .busy       (busy),
    .done       (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (done) done_cnt++;
    if (!reset && addr_valid && addr_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_addr: got %0h expected none", addr_out);
      end else begin
        check("addr_seq", {16'h0, addr_out}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic start_seq(input bit sync, input logic [1:0] rs, input logic [15:0] b,
                           input logic [15:0] o, input logic [15:0] c, input string name);
    if (sync) begin
      @(posedge Clk); #2;
    end
    start  = 1'b1;
    rsel   = rs;
    base   = b;
    offset = o;
    count  = c;
    @(posedge Clk); #2;
    start  = 1'b0;
    rsel   = ~rs;
    base   = 16'hBEEF;
    offset = 16'h1234;
    count  = 16'h0077;
    check({name, "_loadm_valid"}, addr_valid, 0);
    check({name, "_loadm_busy"}, busy, 1);
    check({name, "_raddr"}, m_raddr, rs);
  endtask

  task automatic wait_done(input string name, input int exp_cycles);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (n < 60 && !seen) begin
      @(posedge Clk); #2;
      n++;
      if (done) seen = 1;
    end
    check({name, "_done_cycles"}, seen ? n : -1, exp_cycles);
    check({name, "_done_novalid"}, addr_valid, 0);
    @(posedge Clk); #2;
    check({name, "_done_pulse"}, done, 0);
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    n_checks = 0;
    n_fail = 0;
    done_cnt = 0;
    reset = 1'b1;
    start = 1'b0;
    rsel = 2'd0;
    base = 16'h0;
    offset = 16'h0;
    count = 16'h0;
    addr_ready = 1'b1;
    mreg[0] = 16'h0000;
    mreg[1] = 16'hFFFF;
    mreg[2] = 16'h0009;
    mreg[3] = 16'h00FF;
    #3;
    check("rst_valid", addr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", addr_out, 0);
    check("rst_raddr", m_raddr, 0);
    @(posedge Clk); #2;
    reset = 1'b0;

    exp_q.push_back(16'h0100); exp_q.push_back(16'h0102); exp_q.push_back(16'h0104);
    start_seq(1, 2'd1, 16'h0100, 16'h0002, 16'd3, "lin");
    @(posedge Clk); #2;
    check("lin_first_valid", addr_valid, 1);
    check("lin_first_addr", addr_out, 16'h0100);
    wait_done("lin", 3);

    exp_q.push_back(16'h0025); exp_q.push_back(16'h0028);
    exp_q.push_back(16'h0021); exp_q.push_back(16'h0024);
    start_seq(1, 2'd2, 16'h0025, 16'h0003, 16'd4, "mod");
    wait_done("mod", 5);

    exp_q.push_back(16'h0021); exp_q.push_back(16'h0028);
    start_seq(1, 2'd2, 16'h0021, 16'hFFFD, 16'd2, "modneg");
    wait_done("modneg", 3);

    exp_q.push_back(16'h0000); exp_q.push_back(16'h0008);
    exp_q.push_back(16'h0004); exp_q.push_back(16'h000C);
    start_seq(1, 2'd0, 16'h0000, 16'h0008, 16'd4, "brev");
    wait_done("brev", 5);

    exp_q.push_back(16'h0200); exp_q.push_back(16'h0201); exp_q.push_back(16'h0202);
    start_seq(1, 2'd1, 16'h0200, 16'h0001, 16'd3, "bp");
    @(posedge Clk); #2;
    check("bp_first_addr", addr_out, 16'h0200);
    mreg[1] = 16'h0000;
    @(posedge Clk); #2;
    addr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_addr", addr_out, 16'h0201);
      check("bp_hold_valid", addr_valid, 1);
      if (i == 0) begin
        start = 1'b1; rsel = 2'd2; base = 16'h0500; offset = 16'h0007; count = 16'd9;
      end
      @(posedge Clk); #2;
      start = 1'b0;
    end
    addr_ready = 1'b1;
    wait_done("bp", 2);
    mreg[1] = 16'hFFFF;

    start_seq(1, 2'd1, 16'h0010, 16'h0001, 16'd0, "cnt0");
    wait_done("cnt0", 1);

    exp_q.push_back(16'hFFFF); exp_q.push_back(16'h0000);
    start_seq(1, 2'd1, 16'hFFFF, 16'h0001, 16'd2, "linwrap");
    wait_done("linwrap", 3);

    addr_ready = 1'b0;
    start_seq(1, 2'd1, 16'h0300, 16'h0001, 16'd5, "arst");
    @(posedge Clk); #2;
    check("arst_emit_valid", addr_valid, 1);
    check("arst_emit_addr", addr_out, 16'h0300);
    d0 = done_cnt;
    #1 reset = 1'b1;
    #1;
    check("arst_async_valid", addr_valid, 0);
    check("arst_async_busy", busy, 0);
    check("arst_async_addr", addr_out, 16'h0000);
    repeat (2) @(posedge Clk);
    #2;
    check("arst_no_done", done_cnt, d0);
    reset = 1'b0;
    addr_ready = 1'b1;
    exp_q.push_back(16'h0400); exp_q.push_back(16'h0404);
    start_seq(0, 2'd1, 16'h0400, 16'h0004, 16'd2, "postrst");
    wait_done("postrst", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

endmodule
